// File: rtl/serial_parity_rx_if.sv
// Serial parity link, receive side: line/strobe inputs and decoded word outputs.
interface serial_parity_rx_if #(
   parameter int unsigned DATA_W = 8
) ();
   logic              bit_en;
   logic              rx_in;
   logic [DATA_W-1:0] data_out;
   logic              data_valid;
   logic              parity_err;
   logic              frame_err;
   logic              busy;

   // Line driver / word consumer side.
   modport master (
      output bit_en, rx_in,
      input  data_out, data_valid, parity_err, frame_err, busy
   );

   // Receiver side.
   modport slave (
      input  bit_en, rx_in,
      output data_out, data_valid, parity_err, frame_err, busy
   );
endinterface

// File: rtl/serial_parity_rx.sv
// Deserialises start / DATA_W data bits (LSB first) / parity / stop frames and
// reports the received word with parity and framing error flags.
module serial_parity_rx #(
   parameter int unsigned DATA_W     = 8,
   parameter bit          ODD_PARITY = 1'b0
) (
   input  logic                clk,
   input  logic                rst,
   serial_parity_rx_if.slave   bus
);
   localparam int unsigned CNT_W = $clog2(DATA_W) + 1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   shift_q, shift_d;
   logic                acc_q, acc_d;
   logic                perr_q, perr_d;

   logic [DATA_W-1:0]   data_out_d;
   logic                data_valid_d;
   logic                parity_err_d;
   logic                frame_err_d;
   logic                busy_d;

   // State and registered outputs; reset aborts any frame in progress.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         cnt_q          <= '0;
         shift_q        <= '0;
         acc_q          <= 1'b0;
         perr_q         <= 1'b0;
         bus.data_out   <= '0;
         bus.data_valid <= 1'b0;
         bus.parity_err <= 1'b0;
         bus.frame_err  <= 1'b0;
         bus.busy       <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         shift_q        <= shift_d;
         acc_q          <= acc_d;
         perr_q         <= perr_d;
         bus.data_out   <= data_out_d;
         bus.data_valid <= data_valid_d;
         bus.parity_err <= parity_err_d;
         bus.frame_err  <= frame_err_d;
         bus.busy       <= busy_d;
      end
   end

   // Next-state and output decode; everything advances only on a bit strobe.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      shift_d      = shift_q;
      acc_d        = acc_q;
      perr_d       = perr_q;
      data_out_d   = bus.data_out;
      data_valid_d = 1'b0;
      parity_err_d = bus.parity_err;
      frame_err_d  = bus.frame_err;
      busy_d       = bus.busy;

      if (bus.bit_en) begin
         unique case (state_q)
            ST_IDLE: begin
               if (!bus.rx_in) begin
                  state_d = ST_DATA;
                  cnt_d   = '0;
                  shift_d = '0;
                  acc_d   = 1'b0;
                  busy_d  = 1'b1;
               end
            end
            ST_DATA: begin
               // Shift right so the first (LSB) bit ends up in bit 0.
               shift_d             = shift_q >> 1;
               shift_d[DATA_W-1]   = bus.rx_in;
               acc_d               = acc_q ^ bus.rx_in;
               cnt_d               = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(DATA_W - 1)) begin
                  state_d = ST_PARITY;
               end
            end
            ST_PARITY: begin
               perr_d  = (acc_q ^ bus.rx_in) != ODD_PARITY;
               state_d = ST_STOP;
            end
            ST_STOP: begin
               data_out_d   = shift_q;
               parity_err_d = perr_q;
               frame_err_d  = ~bus.rx_in;
               data_valid_d = 1'b1;
               busy_d       = 1'b0;
               state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_serial_parity_rx.sv
// Directed bench for serial_parity_rx: even- and odd-parity instances share one line.
module tb_serial_parity_rx;
   logic clk;
   logic rst;
   int   vectors;
   int   miscompares;

   serial_parity_rx_if #(.DATA_W(8)) ife ();
   serial_parity_rx_if #(.DATA_W(8)) ifo ();

   assign ifo.bit_en = ife.bit_en;
   assign ifo.rx_in  = ife.rx_in;

   serial_parity_rx #(.DATA_W(8), .ODD_PARITY(1'b0)) u_dut_even (
      .clk (clk),
      .rst (rst),
      .bus (ife)
   );

   serial_parity_rx #(.DATA_W(8), .ODD_PARITY(1'b1)) u_dut_odd (
      .clk (clk),
      .rst (rst),
      .bus (ifo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present one bit on a strobe, preceded by gap non-strobe cycles.
   task automatic drive_bit(input logic b, input int gap, input logic toggle);
      for (int i = 0; i < gap; i++) begin
         @(negedge clk);
         ife.bit_en = 1'b0;
         if (toggle) ife.rx_in = ~ife.rx_in;
      end
      @(negedge clk);
      ife.bit_en = 1'b1;
      ife.rx_in  = b;
   endtask

   // Full frame with busy/valid/word/flag checks on the even instance.
   task automatic send_frame(input string tag, input logic [7:0] d, input logic p,
                             input logic s, input int gap, input logic toggle,
                             input logic exp_perr, input logic exp_ferr);
      drive_bit(1'b0, gap, toggle);
      @(posedge clk); #1;
      chk({tag, "_busy_after_start"}, 32'(ife.busy), 32'd1);
      for (int i = 0; i < 8; i++) drive_bit(d[i], gap, toggle);
      drive_bit(p, gap, toggle);
      drive_bit(s, gap, toggle);
      chk({tag, "_busy_before_stop"}, 32'(ife.busy), 32'd1);
      chk({tag, "_no_early_valid"}, 32'(ife.data_valid), 32'd0);
      @(posedge clk); #1;
      chk({tag, "_valid"}, 32'(ife.data_valid), 32'd1);
      chk({tag, "_busy_done"}, 32'(ife.busy), 32'd0);
      chk({tag, "_data"}, 32'(ife.data_out), 32'(d));
      chk({tag, "_perr"}, 32'(ife.parity_err), 32'(exp_perr));
      chk({tag, "_ferr"}, 32'(ife.frame_err), 32'(exp_ferr));
      @(negedge clk);
      ife.bit_en = 1'b0;
      ife.rx_in  = 1'b1;
      @(posedge clk); #1;
      chk({tag, "_valid_pulse_end"}, 32'(ife.data_valid), 32'd0);
      chk({tag, "_data_held"}, 32'(ife.data_out), 32'(d));
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst         = 1'b1;
      ife.bit_en  = 1'b1;
      ife.rx_in   = 1'b1;

      // Reset held two cycles with strobe active: all outputs clear.
      repeat (2) @(posedge clk);
      #1;
      chk("rst_data", 32'(ife.data_out), 32'd0);
      chk("rst_valid", 32'(ife.data_valid), 32'd0);
      chk("rst_perr", 32'(ife.parity_err), 32'd0);
      chk("rst_ferr", 32'(ife.frame_err), 32'd0);
      chk("rst_busy", 32'(ife.busy), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("idle_busy", 32'(ife.busy), 32'd0);
      chk("idle_valid", 32'(ife.data_valid), 32'd0);

      // Clean frame and parity error cases, one strobe per clock.
      send_frame("a5", 8'hA5, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0);
      send_frame("01_badpar", 8'h01, 1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b0);
      send_frame("03", 8'h03, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0);

      // Bad stop bit, then recovery on the next frame.
      send_frame("3c_badstop", 8'h3C, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
      send_frame("ff", 8'hFF, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0);

      // Sparse strobes with the line toggling between them.
      send_frame("5a_slow", 8'h5A, 1'b0, 1'b1, 3, 1'b1, 1'b0, 1'b0);
      chk("odd_5a_perr", 32'(ifo.parity_err), 32'd1);
      chk("odd_5a_data", 32'(ifo.data_out), 32'h5A);

      // Odd-sense frame: clean for the odd instance, parity error for the even one.
      send_frame("00_p1_even", 8'h00, 1'b1, 1'b1, 0, 1'b0, 1'b1, 1'b0);
      chk("odd_00_perr", 32'(ifo.parity_err), 32'd0);
      chk("odd_00_ferr", 32'(ifo.frame_err), 32'd0);
      chk("odd_00_data", 32'(ifo.data_out), 32'h00);

      // Reset after four data bits of 0x81 aborts the frame.
      drive_bit(1'b0, 0, 1'b0);
      drive_bit(1'b1, 0, 1'b0);
      drive_bit(1'b0, 0, 1'b0);
      drive_bit(1'b0, 0, 1'b0);
      drive_bit(1'b0, 0, 1'b0);
      @(posedge clk); #1;
      chk("abort_busy_pre", 32'(ife.busy), 32'd1);
      @(negedge clk);
      rst        = 1'b1;
      ife.bit_en = 1'b0;
      ife.rx_in  = 1'b1;
      @(posedge clk); #1;
      chk("abort_busy", 32'(ife.busy), 32'd0);
      chk("abort_valid", 32'(ife.data_valid), 32'd0);
      chk("abort_data", 32'(ife.data_out), 32'd0);
      @(negedge clk);
      rst        = 1'b0;
      ife.bit_en = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      chk("abort_no_valid", 32'(ife.data_valid), 32'd0);
      chk("abort_idle_busy", 32'(ife.busy), 32'd0);
      send_frame("81", 8'h81, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Absolute time bound so the run always terminates.
   initial begin
      #200000;
      $display("FAIL timeout vectors=%0d", vectors);
      $fatal(1, "timeout");
   end
endmodule
